// File: rtl/packed_field_assembler.sv
// packed_field_assembler
//
// Builds a packed multi-field word one field per accepted write and presents
// the completed word on a valid/ready output. Field 0 occupies the MSBs, in
// the same order as a packed-struct declaration.
//
// Parameters:
//   NUM_FIELDS    number of fields (2..64)
//   FIELD_W       width of each field in bits (1..64)
//   MODE          0 = named (wr_idx selects the field)
//                 1 = positional (internal pointer, wr_idx ignored)
//   RESET_PATTERN working-word value after reset, output handshake and flush
//   IDX_W         width of wr_idx (derived)
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_valid/wr_ready, wr_idx, wr_data   field write channel
//   flush         abandon the current build
//   out_valid/out_ready, out_data        completed-word channel; out_data
//                                        always shows the working word
//   err           one-cycle pulse after a dropped out-of-range write
module packed_field_assembler #(
    parameter int unsigned                        NUM_FIELDS    = 4,
    parameter int unsigned                        FIELD_W       = 1,
    parameter int unsigned                        MODE          = 0,
    parameter logic [NUM_FIELDS*FIELD_W-1:0]      RESET_PATTERN = 4'b0101,
    parameter int unsigned                        IDX_W         =
        (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [FIELD_W-1:0]             wr_data,
    input  logic                           flush,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0]  out_data,
    output logic                           err
);

    localparam int unsigned WORD_W = NUM_FIELDS * FIELD_W;

    localparam logic [IDX_W:0]        NUM_LIMIT  = (IDX_W + 1)'(NUM_FIELDS);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_FIELDS - 1);
    localparam logic [NUM_FIELDS-1:0] MASK_ONE   = NUM_FIELDS'(1);
    localparam logic [WORD_W-1:0]     FIELD_MASK = WORD_W'({FIELD_W{1'b1}});

    typedef enum logic [0:0] {
        StFill,
        StHold
    } state_e;

    state_e                 state_q;
    logic [WORD_W-1:0]      word_q;
    logic [NUM_FIELDS-1:0]  mask_q;
    logic [IDX_W-1:0]       ptr_q;
    logic                   wr_ready_q;
    logic                   out_valid_q;
    logic                   err_q;

    logic [IDX_W-1:0]       sel;
    logic                   in_range;
    int unsigned            shamt;
    logic [WORD_W-1:0]      word_wr;
    logic [NUM_FIELDS-1:0]  mask_wr;
    logic                   last_write;
    logic [IDX_W-1:0]       ptr_inc;
    logic                   restart;

    // Next-word candidates for an accepted write; only committed by the FSM.
    always_comb begin
        sel      = (MODE != 0) ? ptr_q : wr_idx;
        in_range = (MODE != 0) || ({1'b0, wr_idx} < NUM_LIMIT);

        // An out-of-range sel underflows shamt and shifts everything out, so
        // word_wr/mask_wr collapse to the current values in that case.
        shamt    = (NUM_FIELDS - 1 - 32'(sel)) * FIELD_W;
        word_wr  = (word_q & ~(FIELD_MASK << shamt)) | (WORD_W'(wr_data) << shamt);
        mask_wr  = mask_q | (MASK_ONE << sel);

        last_write = (MODE != 0) ? (ptr_q == LAST_IDX) : (&mask_wr);
        ptr_inc    = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;

        // Flush and output handshake both return to an empty build.
        restart = flush || ((state_q == StHold) && out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            state_q     <= StFill;
            word_q      <= RESET_PATTERN;
            mask_q      <= '0;
            ptr_q       <= '0;
            wr_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StFill: begin
                    if (wr_valid) begin
                        if (in_range) begin
                            word_q <= word_wr;
                            mask_q <= mask_wr;
                            if (MODE != 0) begin
                                ptr_q <= ptr_inc;
                            end
                            if (last_write) begin
                                state_q     <= StHold;
                                wr_ready_q  <= 1'b0;
                                out_valid_q <= 1'b1;
                            end
                        end else begin
                            // Handshaked but dropped.
                            err_q <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    // Writes ignored; the release path is handled by restart.
                end
                default: begin
                    state_q     <= StFill;
                    wr_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready  = wr_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = word_q;
    assign err       = err_q;

endmodule
